opb_register_bank_ppc2simulink: RTL and testbench

// OPB slave exposing N_REGS software-writable 32-bit registers to fabric user logic as one atomic bank.

---
 rtl/opb_register_bank_ppc2simulink_if.sv | 26 ++
 rtl/opb_register_bank_ppc2simulink.sv | 150 +++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// rtl/opb_register_bank_ppc2simulink_if.sv - OPB master/slave signal bundle for the register bank
// Ports (master view): OPB_ABus/OPB_BE/OPB_DBus/OPB_RNW/OPB_select/OPB_seqAddr driven by the master,
// Sl_DBus/Sl_errAck/Sl_retry/Sl_toutSup/Sl_xferAck returned by the slave. Bit 0 is the MSB.
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave exposing an atomically committed bank of 32-bit registers
// Ports: OPB_Clk (sole clock), OPB_Rst (sync active-high reset), opb (OPB slave modport),
//        user_data_out (committed bank, word k at [k*32+31:k*32]), user_load_strobe (1-cycle commit pulse).
// Map: word k at offset 4k, CTRL at 4*N_REGS (bit0 COMMIT, bit1 AUTO, bit2 pending on read),
//      COUNT at 4*N_REGS+4 (16-bit commit counter, read-only).
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01180500,
    parameter logic [31:0] C_HIGHADDR   = 32'h011805FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6",
    parameter int          N_REGS       = 4
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    opb_register_bank_ppc2simulink_if.slave  opb,
    output logic [N_REGS*32-1:0]             user_data_out,
    output logic                             user_load_strobe
);
    localparam logic [29:0] CTRL_IDX  = 30'(N_REGS);
    localparam logic [29:0] COUNT_IDX = 30'(N_REGS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_GAP} state_t;

    state_t      state;
    logic [31:0] shadow [N_REGS];
    logic        auto_mode;
    logic        pending;
    logic [15:0] commit_count;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [29:0] widx_q;
    logic [0:3]  be_q;
    logic [31:0] wdata_q;
    logic        rnw_q;

    logic [31:0] abus;
    logic [31:0] offset;
    logic [29:0] word_now;
    logic        hit;
    logic [31:0] rd_mux;
    logic [31:0] shadow_sel;
    logic [31:0] merged;
    logic        is_shadow;
    logic        is_ctrl;
    logic        unused_cfg;

    assign abus     = opb.OPB_ABus;
    assign offset   = abus - C_BASEADDR;
    assign word_now = offset[31:2];
    assign hit      = opb.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    assign is_shadow = (widx_q < 30'(N_REGS));
    assign is_ctrl   = (widx_q == CTRL_IDX);

    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_DBus    = rdata_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign unused_cfg = ^{opb.OPB_seqAddr, offset[1:0], C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};

    // Read data is captured when the transfer is accepted, so it reflects state before any write of this slot.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (word_now == 30'(k)) rd_mux = shadow[k];
        end
        if (word_now == CTRL_IDX)  rd_mux = {29'b0, pending, auto_mode, 1'b0};
        if (word_now == COUNT_IDX) rd_mux = {16'b0, commit_count};
    end

    // Byte-lane merge: BE[b] owns DBus[8b:8b+7], i.e. little-endian bits 31-8b downto 24-8b.
    always_comb begin
        shadow_sel = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (widx_q == 30'(k)) shadow_sel = shadow[k];
        end
        merged = shadow_sel;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) merged[31-8*b -: 8] = wdata_q[31-8*b -: 8];
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state            <= S_IDLE;
            ack_q            <= 1'b0;
            rdata_q          <= '0;
            user_load_strobe <= 1'b0;
            user_data_out    <= '0;
            auto_mode        <= 1'b0;
            pending          <= 1'b0;
            commit_count     <= '0;
            widx_q           <= '0;
            be_q             <= '0;
            wdata_q          <= '0;
            rnw_q            <= 1'b0;
            for (int k = 0; k < N_REGS; k++) shadow[k] <= '0;
        end else begin
            ack_q            <= 1'b0;
            rdata_q          <= '0;
            user_load_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        state   <= S_ACK;
                        ack_q   <= 1'b1;
                        rnw_q   <= opb.OPB_RNW;
                        widx_q  <= word_now;
                        be_q    <= opb.OPB_BE;
                        wdata_q <= opb.OPB_DBus;
                        if (opb.OPB_RNW) rdata_q <= rd_mux;
                    end
                end
                S_ACK: begin
                    state <= S_GAP;
                    if (!rnw_q) begin
                        if (is_shadow) begin
                            for (int k = 0; k < N_REGS; k++) begin
                                if (widx_q == 30'(k)) begin
                                    shadow[k] <= merged;
                                    if (auto_mode) user_data_out[k*32 +: 32] <= merged;
                                end
                            end
                            // An auto-mode write is itself a commit, so it does not leave work pending.
                            if (auto_mode) begin
                                user_load_strobe <= 1'b1;
                                commit_count     <= commit_count + 16'd1;
                                pending          <= 1'b0;
                            end else begin
                                pending <= 1'b1;
                            end
                        end else if (is_ctrl && be_q[3]) begin
                            auto_mode <= wdata_q[1];
                            if (wdata_q[0]) begin
                                for (int k = 0; k < N_REGS; k++) user_data_out[k*32 +: 32] <= shadow[k];
                                user_load_strobe <= 1'b1;
                                commit_count     <= commit_count + 16'd1;
                                pending          <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - self-checking bench for the OPB register bank
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] BASE = 32'h01180500;
    localparam logic [31:0] HIGH = 32'h011805FF;
    localparam int          N    = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*32-1:0] udo;
    logic           strobe;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink_if opb();

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .C_FAMILY("virtex6"), .N_REGS(N)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .opb(opb), .user_data_out(udo), .user_load_strobe(strobe)
    );

    // Reference model of the register bank contents.
    logic [31:0] sh_m  [N];
    logic [31:0] out_m [N];
    bit          auto_m;
    bit          pend_m;
    logic [15:0] cnt_m;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] off;
        bit          rnw;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          exp_strb;
        int          chk_w;
        logic [31:0] exp_w;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            sh_m[k]  = '0;
            out_m[k] = '0;
        end
        auto_m = 0;
        pend_m = 0;
        cnt_m  = '0;
    endtask

    task automatic model_commit_all();
        for (int k = 0; k < N; k++) out_m[k] = sh_m[k];
        cnt_m  = cnt_m + 16'd1;
        pend_m = 0;
    endtask

    // be[i] enables little-endian byte i (be written MSB-first matches BE[0..3]).
    task automatic model_apply(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                               input logic [31:0] data, output bit hit, output logic [31:0] exp_rd,
                               output int exp_strb);
        int w;
        hit      = (addr >= BASE) && (addr <= HIGH);
        exp_rd   = '0;
        exp_strb = 0;
        w        = int'((addr - BASE) >> 2);
        if (hit) begin
            if (rnw) begin
                if (w < N)           exp_rd = sh_m[w];
                else if (w == N)     exp_rd = {29'b0, pend_m, auto_m, 1'b0};
                else if (w == N + 1) exp_rd = {16'b0, cnt_m};
            end else if (w < N) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) sh_m[w][8*i +: 8] = data[8*i +: 8];
                if (auto_m) begin
                    out_m[w] = sh_m[w];
                    cnt_m    = cnt_m + 16'd1;
                    pend_m   = 0;
                    exp_strb = 1;
                end else begin
                    pend_m = 1;
                end
            end else if (w == N && be[0]) begin
                if (data[0]) begin
                    model_commit_all();
                    exp_strb = 1;
                end
                auto_m = data[1];
            end
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                            input logic [31:0] data, output logic [31:0] rd, output int ack_lat,
                            output int n_ack, output int strb_c, output int n_strb, output int bad_dbus);
        opb.OPB_ABus   = addr;
        opb.OPB_RNW    = rnw;
        opb.OPB_BE     = be;
        opb.OPB_DBus   = data;
        opb.OPB_select = 1'b1;
        rd = '0; ack_lat = 0; n_ack = 0; strb_c = 0; n_strb = 0; bad_dbus = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (opb.Sl_xferAck) begin
                n_ack++;
                if (ack_lat == 0) begin
                    ack_lat = c;
                    rd      = opb.Sl_DBus;
                end
                if (!rnw && opb.Sl_DBus != 0) bad_dbus++;
                opb.OPB_select = 1'b0;
            end else if (opb.Sl_DBus != 0) begin
                bad_dbus++;
            end
            if (strobe) begin
                n_strb++;
                strb_c = c;
            end
        end
        opb.OPB_select = 1'b0;
    endtask

    task automatic do_xfer(input string nm, input logic [31:0] addr, input bit rnw, input logic [3:0] be,
                           input logic [31:0] data, output logic [31:0] rd, output int n_strb);
        bit          hit;
        logic [31:0] exp_rd;
        int          exp_strb, ack_lat, n_ack, strb_c, bad_dbus;
        model_apply(addr, rnw, be, data, hit, exp_rd, exp_strb);
        bus_xfer(addr, rnw, be, data, rd, ack_lat, n_ack, strb_c, n_strb, bad_dbus);
        check({nm, " ack count"}, n_ack, hit ? 1 : 0);
        if (hit) check({nm, " ack latency"}, ack_lat, 1);
        if (hit && rnw) check({nm, " read data"}, rd, exp_rd);
        check({nm, " strobe count"}, n_strb, exp_strb);
        if (exp_strb != 0) check({nm, " strobe cycle"}, strb_c, 2);
        check({nm, " dbus idle zero"}, bad_dbus, 0);
        for (int k = 0; k < N; k++) check({nm, " user word"}, udo[k*32 +: 32], out_m[k]);
    endtask

    initial begin
        logic [31:0] rd, addr, data;
        logic [6:0]  pat;
        int          ns, n;
        bit          rnw;
        logic [3:0]  be;

        tbl[0]  = '{32'h00, 1, 4'hF, 32'h0,        32'h0,        0, -1, 32'h0};
        tbl[1]  = '{32'h10, 1, 4'hF, 32'h0,        32'h0,        0, -1, 32'h0};
        tbl[2]  = '{32'h14, 1, 4'hF, 32'h0,        32'h0,        0, -1, 32'h0};
        tbl[3]  = '{32'h04, 0, 4'hF, 32'hDEADBEEF, 32'h0,        0,  1, 32'h0};
        tbl[4]  = '{32'h10, 1, 4'hF, 32'h0,        32'h4,        0, -1, 32'h0};
        tbl[5]  = '{32'h10, 0, 4'hF, 32'h1,        32'h0,        1,  1, 32'hDEADBEEF};
        tbl[6]  = '{32'h14, 1, 4'hF, 32'h0,        32'h1,        0, -1, 32'h0};
        tbl[7]  = '{32'h10, 1, 4'hF, 32'h0,        32'h0,        0, -1, 32'h0};
        tbl[8]  = '{32'h00, 0, 4'hF, 32'h11223344, 32'h0,        0, -1, 32'h0};
        tbl[9]  = '{32'h00, 0, 4'b0101, 32'hAABBCCDD, 32'h0,     0, -1, 32'h0};
        tbl[10] = '{32'h00, 1, 4'hF, 32'h0,        32'h11BB33DD, 0, -1, 32'h0};
        tbl[11] = '{32'h10, 0, 4'hF, 32'h2,        32'h0,        0, -1, 32'h0};
        tbl[12] = '{32'h08, 0, 4'hF, 32'h12345678, 32'h0,        1,  2, 32'h12345678};
        tbl[13] = '{32'h10, 1, 4'hF, 32'h0,        32'h2,        0,  0, 32'h0};

        opb.OPB_ABus = '0; opb.OPB_BE = '0; opb.OPB_DBus = '0;
        opb.OPB_RNW = 1'b0; opb.OPB_select = 1'b0; opb.OPB_seqAddr = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", opb.Sl_xferAck, 0);
        check("reset dbus", opb.Sl_DBus, 0);
        check("reset strobe", strobe, 0);
        for (int k = 0; k < N; k++) check("reset user word", udo[k*32 +: 32], 0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            do_xfer($sformatf("vec%0d", i), BASE + tbl[i].off, tbl[i].rnw, tbl[i].be, tbl[i].data, rd, ns);
            if (tbl[i].rnw) check($sformatf("vec%0d table read", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d table strobe", i), ns, tbl[i].exp_strb);
            if (tbl[i].chk_w >= 0)
                check($sformatf("vec%0d table word", i), udo[tbl[i].chk_w*32 +: 32], tbl[i].exp_w);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(0, 9));
            if (n == 0) begin
                case ($urandom_range(0, 2))
                    0:       addr = BASE - 32'd4;
                    1:       addr = HIGH + 32'd1;
                    default: addr = $urandom;
                endcase
            end else if (n < 8) begin
                addr = BASE + 32'($urandom_range(0, 7)) * 32'd4;
            end else begin
                addr = BASE + 32'($urandom_range(0, 63)) * 32'd4;
            end
            rnw  = bit'($urandom_range(0, 1));
            be   = 4'($urandom_range(0, 15));
            data = $urandom;
            do_xfer("rand", addr, rnw, be, data, rd, ns);
        end

        // Commit counter wrap: back-to-back commits with select held
        n = 65535 - int'(cnt_m);
        if (n > 0) begin
            opb.OPB_ABus = BASE + 32'h10; opb.OPB_RNW = 1'b0; opb.OPB_BE = 4'hF;
            opb.OPB_DBus = 32'h1; opb.OPB_select = 1'b1;
            repeat (3 * n) @(posedge clk);
            #1;
            opb.OPB_select = 1'b0;
            for (int j = 0; j < n; j++) model_commit_all();
            auto_m = 0;
        end
        do_xfer("count max", BASE + 32'h14, 1, 4'hF, 32'h0, rd, ns);
        check("count max value", rd, 32'h0000FFFF);
        do_xfer("wrap commit", BASE + 32'h10, 0, 4'hF, 32'h1, rd, ns);
        do_xfer("count wrap", BASE + 32'h14, 1, 4'hF, 32'h0, rd, ns);
        check("count wrap value", rd, 32'h0);

        // Throughput: select held on a read acks once every three cycles
        opb.OPB_ABus = BASE; opb.OPB_RNW = 1'b1; opb.OPB_BE = 4'hF; opb.OPB_select = 1'b1;
        pat = '0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            pat[c-1] = opb.Sl_xferAck;
        end
        opb.OPB_select = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held select ack pattern", 32'(pat), 32'b1001001);

        // Reset asserted during the ACK cycle of a write
        do_xfer("pre reset auto", BASE + 32'h10, 0, 4'hF, 32'h2, rd, ns);
        opb.OPB_ABus = BASE + 32'h0C; opb.OPB_RNW = 1'b0; opb.OPB_BE = 4'hF;
        opb.OPB_DBus = 32'hCAFEF00D; opb.OPB_select = 1'b1;
        @(posedge clk); #1;
        check("mid reset ack seen", opb.Sl_xferAck, 1);
        rst = 1'b1;
        opb.OPB_select = 1'b0;
        @(posedge clk); #1;
        check("mid reset ack", opb.Sl_xferAck, 0);
        check("mid reset dbus", opb.Sl_DBus, 0);
        check("mid reset strobe", strobe, 0);
        for (int k = 0; k < N; k++) check("mid reset user word", udo[k*32 +: 32], 0);
        rst = 1'b0;
        model_reset();
        do_xfer("post reset word3", BASE + 32'h0C, 1, 4'hF, 32'h0, rd, ns);
        check("post reset word3 value", rd, 32'h0);
        do_xfer("post reset ctrl", BASE + 32'h10, 1, 4'hF, 32'h0, rd, ns);
        do_xfer("post reset count", BASE + 32'h14, 1, 4'hF, 32'h0, rd, ns);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
